// File: rtl/dac_table_8x_deadlock_pkg.sv
// -----------------------------------------------------------------------------
// dac_table_8x_deadlock_pkg
// Shared types and helpers for the dac_table_8x deadlock watchdog.
//   state_t     : watchdog FSM states (idle, counting a stall, sticky deadlock)
//   sat_max     : all-ones value for a counter of a given width
//   cause_width : width of the block-cause snapshot (streams + instances)
// -----------------------------------------------------------------------------
package dac_table_8x_deadlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STALLED  = 2'd1,
        ST_DEADLOCK = 2'd2
    } state_t;

    // Largest value a WIDTH-bit counter can hold; the counters stop here.
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

    // Stream flags occupy the low bits of the cause vector, instances the high bits.
    function automatic int cause_width(input int n_axis, input int n_inst);
        return n_axis + n_inst;
    endfunction

endpackage

// File: rtl/dac_table_8x_sat_counter.sv
// -----------------------------------------------------------------------------
// dac_table_8x_sat_counter
// Saturating up-counter with synchronous clear.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   inc          : add one this cycle unless already at the maximum
//   clear        : force the count to zero (wins over inc)
//   count        : registered count
//   count_next   : value the count takes on the coming edge
// -----------------------------------------------------------------------------
module dac_table_8x_sat_counter
    import dac_table_8x_deadlock_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(sat_max(WIDTH));

    // The next value is exported so the owner can track a maximum
    // that already includes the current edge.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (inc && (count != MAX_VAL)) begin
            count_next = count + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/dac_table_8x_deadlock_watchdog.sv
// -----------------------------------------------------------------------------
// dac_table_8x_deadlock_watchdog
// Registers the OR of all stream/instance block flags and declares a sticky
// deadlock once the block has persisted for THRESHOLD consecutive enabled
// cycles. Captures which sources were blocking and the longest stall seen.
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   axis_block_sigs  : per-stream blocked flags
//   inst_block_sigs  : per-instance blocked flags
//   inst_idle_sigs   : per-instance idle flags (idle masks the block flag)
//   enable           : arms deadlock detection
//   clear            : releases a deadlock and clears the debug registers
//   block            : registered raw block indication
//   deadlock         : sticky deadlock flag
//   block_cause      : source snapshot at deadlock entry {instances, streams}
//   stall_cycles     : current consecutive-block count
//   max_stall        : longest stall since reset or clear
// -----------------------------------------------------------------------------
module dac_table_8x_deadlock_watchdog
    import dac_table_8x_deadlock_pkg::*;
#(
    parameter int N_AXIS    = 3,
    parameter int N_INST    = 2,
    parameter int CNT_W     = 16,
    parameter int THRESHOLD = 1024
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [N_AXIS-1:0]                         axis_block_sigs,
    input  logic [((N_INST > 0) ? N_INST : 1)-1:0]    inst_block_sigs,
    input  logic [((N_INST > 0) ? N_INST : 1)-1:0]    inst_idle_sigs,
    input  logic                                      enable,
    input  logic                                      clear,
    output logic                                      block,
    output logic                                      deadlock,
    output logic [cause_width(N_AXIS, N_INST)-1:0]    block_cause,
    output logic [CNT_W-1:0]                          stall_cycles,
    output logic [CNT_W-1:0]                          max_stall
);

    localparam int               CAUSE_W   = cause_width(N_AXIS, N_INST);
    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESHOLD - 1);

    logic [CAUSE_W-1:0] src;
    logic               any_block;
    state_t             state;
    state_t             state_next;
    logic               cnt_inc;
    logic               cnt_clr;
    logic               cause_load;
    logic [CNT_W-1:0]   cnt_next;

    // With no sub-instances the instance ports are single dummy bits and are ignored.
    generate
        if (N_INST > 0) begin : g_inst
            assign src = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs};
        end else begin : g_no_inst
            logic unused_inst;
            assign unused_inst = ^{inst_block_sigs, inst_idle_sigs};
            assign src = axis_block_sigs;
        end
    endgenerate

    assign any_block = |src;
    assign deadlock  = (state == ST_DEADLOCK);

    dac_table_8x_sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clock      (clock),
        .reset      (reset),
        .inc        (cnt_inc),
        .clear      (cnt_clr),
        .count      (stall_cycles),
        .count_next (cnt_next)
    );

    // Next-state logic. Entry to DEADLOCK is decided on the same edge that
    // makes the count reach THRESHOLD, so STALLED compares against THRESHOLD-1.
    // A clear overrides everything, including a deadlock entry on that edge.
    always_comb begin
        state_next = state;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        cause_load = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (enable && any_block) begin
                    cnt_inc = 1'b1;
                    if (THRESHOLD == 1) begin
                        state_next = ST_DEADLOCK;
                        cause_load = 1'b1;
                    end else begin
                        state_next = ST_STALLED;
                    end
                end
            end
            ST_STALLED: begin
                if (enable && any_block) begin
                    cnt_inc = 1'b1;
                    if (stall_cycles == THRESH_M1) begin
                        state_next = ST_DEADLOCK;
                        cause_load = 1'b1;
                    end
                end else begin
                    state_next = ST_IDLE;
                    cnt_clr    = 1'b1;
                end
            end
            ST_DEADLOCK: begin
                cnt_inc = any_block;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_clr    = 1'b1;
            end
        endcase
        if (clear) begin
            state_next = ST_IDLE;
            cnt_clr    = 1'b1;
            cause_load = 1'b0;
        end
    end

    // State, raw block level, cause snapshot and running maximum.
    // The maximum compares against the counter's next value so it already
    // reflects the current edge, and saturates along with the counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            block       <= 1'b0;
            block_cause <= '0;
            max_stall   <= '0;
        end else begin
            state <= state_next;
            block <= any_block;
            if (clear) begin
                block_cause <= '0;
                max_stall   <= '0;
            end else begin
                if (cause_load) begin
                    block_cause <= src;
                end
                if (cnt_next > max_stall) begin
                    max_stall <= cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_table_8x_deadlock_watchdog.sv
// -----------------------------------------------------------------------------
// tb_dac_table_8x_deadlock_watchdog
// Self-checking bench for the deadlock watchdog. Two instances share inputs:
// dut (CNT_W=16, THRESHOLD=8) and dut_sat (CNT_W=4, THRESHOLD=15). Expected
// output vectors are queued when inputs are driven and popped after the edge.
// -----------------------------------------------------------------------------
module tb_dac_table_8x_deadlock_watchdog;

    logic        clock;
    logic        reset;
    logic [2:0]  axis_block_sigs;
    logic [1:0]  inst_block_sigs;
    logic [1:0]  inst_idle_sigs;
    logic        enable;
    logic        clear;

    logic        block;
    logic        deadlock;
    logic [4:0]  block_cause;
    logic [15:0] stall_cycles;
    logic [15:0] max_stall;

    logic        block_s;
    logic        deadlock_s;
    logic [4:0]  block_cause_s;
    logic [3:0]  stall_cycles_s;
    logic [3:0]  max_stall_s;

    int total;
    int bad;

    logic [38:0] sbq[$];

    dac_table_8x_deadlock_watchdog #(
        .N_AXIS(3), .N_INST(2), .CNT_W(16), .THRESHOLD(8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .inst_block_sigs (inst_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .enable          (enable),
        .clear           (clear),
        .block           (block),
        .deadlock        (deadlock),
        .block_cause     (block_cause),
        .stall_cycles    (stall_cycles),
        .max_stall       (max_stall)
    );

    dac_table_8x_deadlock_watchdog #(
        .N_AXIS(3), .N_INST(2), .CNT_W(4), .THRESHOLD(15)
    ) dut_sat (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .inst_block_sigs (inst_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .enable          (enable),
        .clear           (clear),
        .block           (block_s),
        .deadlock        (deadlock_s),
        .block_cause     (block_cause_s),
        .stall_cycles    (stall_cycles_s),
        .max_stall       (max_stall_s)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no end of test, want finish before 200000");
        $fatal(1);
    end

    function automatic logic [38:0] pack_exp(input logic b, input logic d,
                                             input logic [4:0] c,
                                             input logic [15:0] s,
                                             input logic [15:0] m);
        return {b, d, c, s, m};
    endfunction

    // Zero all inputs and pulse clear for one edge; leaves both DUTs idle.
    task automatic pulse_clear();
        axis_block_sigs = '0;
        inst_block_sigs = '0;
        inst_idle_sigs  = '0;
        enable          = 1'b0;
        clear           = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [38:0] got;
        logic [38:0] got_s;
        reset           = 1'b1;
        axis_block_sigs = 3'b111;
        inst_block_sigs = 2'b11;
        inst_idle_sigs  = 2'b00;
        enable          = 1'b1;
        clear           = 1'b0;
        #2;
        got   = {block, deadlock, block_cause, stall_cycles, max_stall};
        got_s = {block_s, deadlock_s, block_cause_s, 12'b0, stall_cycles_s, 12'b0, max_stall_s};
        total += 2;
        if (got !== 39'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: got %h want %h", got, 39'b0);
        end
        if (got_s !== 39'b0) begin
            bad++;
            $display("[TB] FAIL reset_state_sat: got %h want %h", got_s, 39'b0);
        end
        @(posedge clock); #1;
        got = {block, deadlock, block_cause, stall_cycles, max_stall};
        total++;
        if (got !== 39'b0) begin
            bad++;
            $display("[TB] FAIL reset_held_over_edge: got %h want %h", got, 39'b0);
        end
        axis_block_sigs = '0;
        inst_block_sigs = '0;
        enable          = 1'b0;
        #3;
        reset = 1'b0;
        sbq.push_back(pack_exp(1'b0, 1'b0, 5'b0, 16'd0, 16'd0));
        @(posedge clock); #1;
        got = {block, deadlock, block_cause, stall_cycles, max_stall};
        total++;
        if (got !== sbq[0]) begin
            bad++;
            $display("[TB] FAIL reset_release: got %h want %h", got, sbq[0]);
        end
        void'(sbq.pop_front());
    endtask

    task automatic test_threshold();
        logic [38:0] got;
        logic [38:0] exp;
        pulse_clear();
        axis_block_sigs = 3'b010;
        enable          = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            sbq.push_back(pack_exp(1'b1, k >= 8, (k >= 8) ? 5'b00010 : 5'b00000,
                                   16'(k), 16'(k)));
            @(posedge clock); #1;
            exp = sbq.pop_front();
            got = {block, deadlock, block_cause, stall_cycles, max_stall};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL threshold edge %0d: got %h want %h", k, got, exp);
            end
        end
    endtask

    task automatic test_gap();
        logic [38:0] got;
        logic [38:0] exp;
        logic [11:0] pattern;
        int          run;
        pulse_clear();
        pattern = 12'b0_11111_0_11111;
        run     = 0;
        enable  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            axis_block_sigs = pattern[k] ? 3'b001 : 3'b000;
            run = pattern[k] ? run + 1 : 0;
            sbq.push_back(pack_exp(pattern[k], 1'b0, 5'b0, 16'(run), 16'((k < 5) ? k + 1 : 5)));
            @(posedge clock); #1;
            exp = sbq.pop_front();
            got = {block, deadlock, block_cause, stall_cycles, max_stall};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL gap edge %0d: got %h want %h", k + 1, got, exp);
            end
        end
    endtask

    task automatic test_idle_mask();
        logic [38:0] got;
        logic [38:0] exp;
        pulse_clear();
        inst_block_sigs = 2'b01;
        inst_idle_sigs  = 2'b01;
        enable          = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            sbq.push_back(pack_exp(1'b0, 1'b0, 5'b0, 16'd0, 16'd0));
            @(posedge clock); #1;
            exp = sbq.pop_front();
            got = {block, deadlock, block_cause, stall_cycles, max_stall};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL idle_masked edge %0d: got %h want %h", k, got, exp);
            end
        end
        inst_idle_sigs = 2'b00;
        for (int k = 1; k <= 9; k++) begin
            sbq.push_back(pack_exp(1'b1, k >= 8, (k >= 8) ? 5'b01000 : 5'b00000,
                                   16'(k), 16'(k)));
            @(posedge clock); #1;
            exp = sbq.pop_front();
            got = {block, deadlock, block_cause, stall_cycles, max_stall};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL idle_unmasked edge %0d: got %h want %h", k, got, exp);
            end
        end
    endtask

    task automatic test_clear_race();
        logic [38:0] got;
        logic [38:0] exp;
        int          cnt;
        pulse_clear();
        axis_block_sigs = 3'b001;
        enable          = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            clear = (k == 8);
            cnt   = (k < 8) ? k : ((k == 8) ? 0 : k - 8);
            sbq.push_back(pack_exp(1'b1, k >= 16, (k >= 16) ? 5'b00001 : 5'b00000,
                                   16'(cnt), 16'(cnt)));
            @(posedge clock); #1;
            exp = sbq.pop_front();
            got = {block, deadlock, block_cause, stall_cycles, max_stall};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL clear_race edge %0d: got %h want %h", k, got, exp);
            end
        end
        clear = 1'b0;
    endtask

    task automatic test_saturation();
        logic [38:0] got;
        logic [38:0] exp;
        int          sat;
        pulse_clear();
        axis_block_sigs = 3'b100;
        enable          = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            sat = (k > 15) ? 15 : k;
            sbq.push_back(pack_exp(1'b1, k >= 15, (k >= 15) ? 5'b00100 : 5'b00000,
                                   16'(sat), 16'(sat)));
            @(posedge clock); #1;
            exp = sbq.pop_front();
            got = {block_s, deadlock_s, block_cause_s, 12'b0, stall_cycles_s, 12'b0, max_stall_s};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL saturate edge %0d: got %h want %h", k, got, exp);
            end
        end
        // Dropping enable must not release the deadlock; only clear does.
        enable = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            clear = (k == 6);
            if (k < 6) begin
                sbq.push_back(pack_exp(1'b1, 1'b1, 5'b00100, 16'd15, 16'd15));
            end else begin
                sbq.push_back(pack_exp(1'b1, 1'b0, 5'b00000, 16'd0, 16'd0));
            end
            @(posedge clock); #1;
            exp = sbq.pop_front();
            got = {block_s, deadlock_s, block_cause_s, 12'b0, stall_cycles_s, 12'b0, max_stall_s};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL sticky_until_clear step %0d: got %h want %h", k, got, exp);
            end
        end
        clear = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [38:0] got;
        logic [38:0] exp;
        pulse_clear();
        axis_block_sigs = 3'b010;
        enable          = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            sbq.push_back(pack_exp(1'b1, k >= 8, (k >= 8) ? 5'b00010 : 5'b00000,
                                   16'(k), 16'(k)));
            @(posedge clock); #1;
            exp = sbq.pop_front();
            got = {block, deadlock, block_cause, stall_cycles, max_stall};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL pre_reset edge %0d: got %h want %h", k, got, exp);
            end
        end
        // Assert reset between edges; outputs must drop without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        got = {block, deadlock, block_cause, stall_cycles, max_stall};
        total++;
        if (got !== 39'b0) begin
            bad++;
            $display("[TB] FAIL async_reset_drop: got %h want %h", got, 39'b0);
        end
        #2;
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            sbq.push_back(pack_exp(1'b1, k >= 8, (k >= 8) ? 5'b00010 : 5'b00000,
                                   16'(k), 16'(k)));
            @(posedge clock); #1;
            exp = sbq.pop_front();
            got = {block, deadlock, block_cause, stall_cycles, max_stall};
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL post_reset edge %0d: got %h want %h", k, got, exp);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_threshold();
        test_gap();
        test_idle_mask();
        test_clear_race();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_table_8x_deadlock_watchdog.md
# dac_table_8x_deadlock_watchdog

Parametrised deadlock watchdog for the dac_table_8x HLS datapath. It ORs an arbitrary number of AXI-Stream block indications and sub-instance block indications into a registered `block` level, as the per-loop monitors do. Unlike those monitors, it also requires a block to persist for a programmable number of cycles before it declares a sticky deadlock. It latches which sources caused the deadlock and tracks the longest stall seen, for debug readout by the control plane.

## Interface
Parameters:
- `N_AXIS`, default 3: number of AXI-Stream block inputs, ≥1.
- `N_INST`, default 2: number of sub-instance block/idle pairs, ≥0; when 0 the instance ports are tied off internally.
- `CNT_W`, default 16: stall counter width.
- `THRESHOLD`, default 1024: consecutive blocked cycles that declare deadlock; legal range 1 … 2^CNT_W−1.

Ports:
- `clock`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `axis_block_sigs`, in, N_AXIS: per-stream blocked flags.
- `inst_block_sigs`, in, N_INST: per-instance blocked flags.
- `inst_idle_sigs`, in, N_INST: per-instance idle flags; an idle instance's block flag is ignored.
- `enable`, in, 1: arms deadlock detection.
- `clear`, in, 1: single-cycle pulse that releases a declared deadlock and clears the debug registers.
- `block`, out, 1: registered raw block indication.
- `deadlock`, out, 1: sticky deadlock flag.
- `block_cause`, out, N_AXIS+N_INST: source snapshot taken at deadlock; bits [N_AXIS−1:0] are streams, the upper bits are instances.
- `stall_cycles`, out, CNT_W: current consecutive-block count.
- `max_stall`, out, CNT_W: longest stall observed since reset or clear.

## Operation
- Combinational `src = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs}`; `any_block = |src`.
- `block` is `any_block` registered every cycle, independent of `enable` and state.
- States:
  - IDLE: counter is 0.
  - STALLED: counting.
  - DEADLOCK: sticky.
- IDLE → STALLED when `enable & any_block`; counter becomes 1. If THRESHOLD=1, the state goes straight to DEADLOCK instead.
- STALLED:
  - `any_block` high → counter +1.
  - When the incremented value equals THRESHOLD → DEADLOCK, and `block_cause` is loaded with the current `src`.
  - `any_block` low → IDLE, counter 0.
  - `enable` low → IDLE, counter 0.
- DEADLOCK:
  - `deadlock`=1; `block_cause` is frozen.
  - The counter keeps incrementing while `any_block` is high and saturates at 2^CNT_W−1. It holds when `any_block` is low.
  - Exit only via `clear` → IDLE.
- `max_stall` updates to `stall_cycles` whenever the latter is larger; it saturates with the counter.
- `clear`:
  - Forces IDLE and zeroes the counter, `block_cause` and `max_stall` in any state.
  - `clear` beats a same-cycle DEADLOCK entry: the deadlock is not declared and the cause is not latched.
  - `block` is not affected by `clear`.
- `enable` low never releases DEADLOCK.
- Deadlock entry is evaluated on the same edge as the increment.

## Timing
- Reset value of every output is 0, and the state resets to IDLE.
- `block`: 1-cycle latency from inputs.
- `deadlock`: rises on the THRESHOLD-th consecutive rising edge at which `enable & any_block` is sampled high. With a sustained block starting before edge 1, `deadlock` is high after edge THRESHOLD.
- `stall_cycles` and `max_stall` are registered; they show the count including the current edge.
- `clear` takes effect on the next edge; outputs read 0 after it.
- Reset asserted mid-stall or mid-deadlock: all outputs drop to 0 asynchronously. After release, detection restarts from IDLE.

## Structure
- Package `dac_table_8x_deadlock_pkg`:
  - state enum `{ST_IDLE, ST_STALLED, ST_DEADLOCK}`;
  - the saturating-maximum constant helper;
  - the cause-width function (N_AXIS+N_INST).
- One sub-module, `dac_table_8x_sat_counter`, of width CNT_W with inc, clear and saturation. It is instantiated once for the stall counter; the max tracker is a compare-and-load register in the top.

## Test plan
- THRESHOLD=8: hold `axis_block_sigs`=3'b010 with `enable`=1 → `block`=1 after 1 cycle; `deadlock`=1 after edge 8; `block_cause`=5'b00010; `stall_cycles`=8.
- Block for 5 cycles, drop for 1, block for 5 → no deadlock; `stall_cycles` returns to 0 in the gap; `max_stall`=5.
- `inst_block_sigs`=2'b01 with `inst_idle_sigs`=2'b01 → `block`=0 and no count. Then clear the idle bit → counting starts; the cause at deadlock is 5'b01000.
- Assert `clear` on the exact edge the count reaches THRESHOLD → `deadlock` stays 0 and the counter returns to 0. A sustained block then re-declares deadlock THRESHOLD edges later.
- CNT_W=4, THRESHOLD=15, block for 40 cycles → deadlock at edge 15; `stall_cycles` saturates at 15; `max_stall`=15. Drop `enable` → `deadlock` remains 1 until `clear`.
- Assert `reset` asynchronously mid-deadlock (between clock edges) → all outputs 0 immediately. Release it with the block held → `block` returns 1 cycle later and deadlock is re-declared after THRESHOLD edges.
